// File: rtl/fifo_group_accum_if.sv
// Handshake bundle between fifo_group_accum, its upstream FIFO (first/deq) and its downstream enq sink.
// The slave modport is the accumulator's view; master is the view of whatever drives it.
interface fifo_group_accum_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] in_first;
  logic                  in_first__RDY;
  logic                  in_deq__RDY;
  logic                  in_deq__ENA;
  logic                  out_enq__RDY;
  logic                  out_enq__ENA;
  logic [DATA_WIDTH-1:0] out_enq_v;
  logic                  busy;
  logic [15:0]           group_count;

  modport master (
    output in_first, in_first__RDY, in_deq__RDY, out_enq__RDY,
    input  in_deq__ENA, out_enq__ENA, out_enq_v, busy, group_count
  );

  modport slave (
    input  in_first, in_first__RDY, in_deq__RDY, out_enq__RDY,
    output in_deq__ENA, out_enq__ENA, out_enq_v, busy, group_count
  );
endinterface

// File: rtl/fifo_group_accum.sv
// Drains an upstream FIFO word by word, sums each run of GROUP words and pushes
// the sum downstream; accumulation and emission never overlap.
module fifo_group_accum #(
  parameter int GROUP      = 4,
  parameter int DATA_WIDTH = 32
) (
  input logic              CLK,
  input logic              nRST,
  fifo_group_accum_if.slave bus
);

  typedef enum logic [0:0] {ACCUM, EMIT} state_t;

  localparam logic [7:0] LAST = 8'(GROUP - 1);

  state_t                state, state_next;
  logic [7:0]            count, count_next;
  logic [DATA_WIDTH-1:0] acc, acc_next;
  logic [15:0]           group_count_q, group_count_next;
  logic                  pop, push;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state         <= ACCUM;
      count         <= '0;
      acc           <= '0;
      group_count_q <= '0;
    end else begin
      state         <= state_next;
      count         <= count_next;
      acc           <= acc_next;
      group_count_q <= group_count_next;
    end
  end

  always_comb begin
    state_next       = state;
    count_next       = count;
    acc_next         = acc;
    group_count_next = group_count_q;
    pop              = 1'b0;
    push             = 1'b0;
    case (state)
      ACCUM: begin
        pop = bus.in_first__RDY & bus.in_deq__RDY;
        if (pop) begin
          // The first word of a group overwrites whatever the last sum left behind.
          acc_next = (count == 8'd0) ? bus.in_first : acc + bus.in_first;
          if (count == LAST) begin
            count_next = '0;
            state_next = EMIT;
          end else begin
            count_next = count + 8'd1;
          end
        end
      end
      EMIT: begin
        push = bus.out_enq__RDY;
        if (push) begin
          state_next       = ACCUM;
          group_count_next = group_count_q + 16'd1;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  // Handshakes and status are held low while reset is asserted.
  assign bus.in_deq__ENA  = pop & nRST;
  assign bus.out_enq__ENA = push & nRST;
  assign bus.out_enq_v    = nRST ? acc : '0;
  assign bus.busy         = nRST & ((state == EMIT) | (count != 8'd0));
  assign bus.group_count  = group_count_q;

endmodule

// File: tb/tb_fifo_group_accum.sv
// Scoreboard bench for fifo_group_accum: one GROUP=4 and one GROUP=1 instance, directed
// cases followed by random words, gaps and backpressure checked against a group-sum model.
module tb_fifo_group_accum;

  logic clk;
  logic nrst0, nrst1;

  fifo_group_accum_if #(.DATA_WIDTH(32)) if0 ();
  fifo_group_accum_if #(.DATA_WIDTH(32)) if1 ();

  fifo_group_accum #(.GROUP(4), .DATA_WIDTH(32)) dut0 (.CLK(clk), .nRST(nrst0), .bus(if0));
  fifo_group_accum #(.GROUP(1), .DATA_WIDTH(32)) dut1 (.CLK(clk), .nRST(nrst1), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q [2][$];
  logic [31:0] part_sum [2];
  int          part_n [2];
  logic [15:0] exp_gc [2];
  logic        rand_rdy [2];

  function automatic int group_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  task automatic cmp(input int i, input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL u%0d %s: got %h expected %h at %0t", i, name, act, exp, $time);
    end
  endtask

  // Model: a group is just the list of popped words; its sum is due downstream once GROUP words arrived.
  task automatic check_cycle(input int i, input logic rst_n, input logic [31:0] first,
                             input logic first_rdy, input logic deq_rdy, input logic deq_ena,
                             input logic out_rdy, input logic out_ena, input logic [31:0] out_v,
                             input logic busy, input logic [15:0] gc);
    logic exp_busy;
    if (!rst_n) begin
      cmp(i, "rst_deq_ena", {31'd0, deq_ena}, 32'd0);
      cmp(i, "rst_enq_ena", {31'd0, out_ena}, 32'd0);
      cmp(i, "rst_enq_v", out_v, 32'd0);
      cmp(i, "rst_busy", {31'd0, busy}, 32'd0);
      exp_q[i].delete();
      part_n[i]   = 0;
      part_sum[i] = '0;
      exp_gc[i]   = '0;
      return;
    end
    cmp(i, "group_count", {16'd0, gc}, {16'd0, exp_gc[i]});
    exp_busy = (part_n[i] != 0) || (exp_q[i].size() != 0);
    cmp(i, "busy", {31'd0, busy}, {31'd0, exp_busy});
    if (exp_q[i].size() != 0) begin
      cmp(i, "deq_ena_hold", {31'd0, deq_ena}, 32'd0);
      cmp(i, "enq_ena", {31'd0, out_ena}, {31'd0, out_rdy});
      cmp(i, "enq_v", out_v, exp_q[i][0]);
      if (out_ena) begin
        void'(exp_q[i].pop_front());
        exp_gc[i] = exp_gc[i] + 16'd1;
      end
    end else begin
      cmp(i, "enq_ena_idle", {31'd0, out_ena}, 32'd0);
      cmp(i, "deq_ena", {31'd0, deq_ena}, {31'd0, first_rdy & deq_rdy});
      if (deq_ena) begin
        part_sum[i] = part_sum[i] + first;
        part_n[i]++;
        if (part_n[i] == group_of(i)) begin
          exp_q[i].push_back(part_sum[i]);
          part_sum[i] = '0;
          part_n[i]   = 0;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    check_cycle(0, nrst0, if0.in_first, if0.in_first__RDY, if0.in_deq__RDY, if0.in_deq__ENA,
                if0.out_enq__RDY, if0.out_enq__ENA, if0.out_enq_v, if0.busy, if0.group_count);
    check_cycle(1, nrst1, if1.in_first, if1.in_first__RDY, if1.in_deq__RDY, if1.in_deq__ENA,
                if1.out_enq__RDY, if1.out_enq__ENA, if1.out_enq_v, if1.busy, if1.group_count);
  end

  function automatic logic deq_ena_of(input int i);
    return (i == 0) ? if0.in_deq__ENA : if1.in_deq__ENA;
  endfunction

  task automatic drive_in(input int i, input logic v, input logic [31:0] d);
    if (i == 0) begin
      if0.in_first = d; if0.in_first__RDY = v; if0.in_deq__RDY = v;
    end else begin
      if1.in_first = d; if1.in_first__RDY = v; if1.in_deq__RDY = v;
    end
  endtask

  task automatic set_out_rdy(input int i, input logic r);
    if (i == 0) if0.out_enq__RDY = r;
    else        if1.out_enq__RDY = r;
  endtask

  task automatic tick(input int i);
    @(posedge clk);
    #1;
    if (rand_rdy[i]) set_out_rdy(i, 1'($urandom_range(0, 1)));
  endtask

  task automatic send_word(input int i, input logic [31:0] d);
    logic got;
    got = 1'b0;
    drive_in(i, 1'b1, d);
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (deq_ena_of(i)) begin
        got = 1'b1;
        break;
      end
      tick(i);
    end
    tick(i);
    drive_in(i, 1'b0, 32'd0);
    vectors++;
    if (!got) begin
      miscompares++;
      $display("[TB] FAIL u%0d pop_timeout: got no deq expected deq of %h", i, d);
    end
  endtask

  task automatic drain(input int i);
    logic done;
    done = 1'b0;
    for (int n = 0; n < 80; n++) begin
      if (exp_q[i].size() == 0 && part_n[i] == 0) begin
        done = 1'b1;
        break;
      end
      tick(i);
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("[TB] FAIL u%0d drain_timeout: got %0d pending expected 0", i, exp_q[i].size());
    end
  endtask

  task automatic pulse_reset(input int i);
    if (i == 0) nrst0 = 1'b0; else nrst1 = 1'b0;
    tick(i);
    if (i == 0) nrst0 = 1'b1; else nrst1 = 1'b1;
  endtask

  task automatic applyStimulus();
    // T1 basic and T2 wrap-around sum on the GROUP=4 unit.
    set_out_rdy(0, 1'b1);
    send_word(0, 32'd1); send_word(0, 32'd2); send_word(0, 32'd3); send_word(0, 32'd4);
    drain(0);
    @(negedge clk);
    cmp(0, "t1_group_count", {16'd0, if0.group_count}, 32'd1);
    cmp(0, "t1_busy_after", {31'd0, if0.busy}, 32'd0);
    tick(0);
    send_word(0, 32'hFFFF_FFFF); send_word(0, 32'd2); send_word(0, 32'd0); send_word(0, 32'd0);
    drain(0);

    // T3 backpressure: upstream stays full while the finished sum waits.
    set_out_rdy(0, 1'b0);
    send_word(0, 32'd10); send_word(0, 32'd20); send_word(0, 32'd30); send_word(0, 32'd40);
    drive_in(0, 1'b1, 32'd5);
    repeat (5) begin
      @(negedge clk);
      cmp(0, "t3_deq_blocked", {31'd0, if0.in_deq__ENA}, 32'd0);
      cmp(0, "t3_enq_v_stable", if0.out_enq_v, 32'd100);
      tick(0);
    end
    set_out_rdy(0, 1'b1);
    @(negedge clk);
    cmp(0, "t3_emit_on_rdy", {31'd0, if0.out_enq__ENA}, 32'd1);
    tick(0);
    send_word(0, 32'd5); send_word(0, 32'd5); send_word(0, 32'd5); send_word(0, 32'd5);
    drain(0);

    // T4 reset mid-group discards the partial sum.
    send_word(0, 32'd7); send_word(0, 32'd7);
    pulse_reset(0);
    send_word(0, 32'd1); send_word(0, 32'd1); send_word(0, 32'd1); send_word(0, 32'd1);
    drain(0);
    @(negedge clk);
    cmp(0, "t4_group_count", {16'd0, if0.group_count}, 32'd1);
    tick(0);

    // T5 GROUP=1 stream with the upstream valid every second cycle.
    set_out_rdy(1, 1'b1);
    send_word(1, 32'd5); tick(1);
    send_word(1, 32'd6); tick(1);
    send_word(1, 32'd7); tick(1);
    drain(1);

    // T6 group_count wrap, preloaded to 0xFFFF instead of 65535 real emits.
    force dut1.group_count_q = 16'hFFFF;
    exp_gc[1] = 16'hFFFF;
    tick(1);
    release dut1.group_count_q;
    tick(1);
    send_word(1, 32'd9);
    drain(1);
    @(negedge clk);
    cmp(1, "t6_gc_wrap", {16'd0, if1.group_count}, 32'd0);
    tick(1);

    // Random words, gaps and downstream backpressure on both units.
    rand_rdy[0] = 1'b1;
    for (int k = 0; k < 160; k++) begin
      send_word(0, $urandom());
      repeat ($urandom_range(0, 3)) tick(0);
    end
    rand_rdy[0] = 1'b0;
    set_out_rdy(0, 1'b1);
    drain(0);
    rand_rdy[1] = 1'b1;
    for (int k = 0; k < 60; k++) begin
      send_word(1, $urandom());
      repeat ($urandom_range(0, 2)) tick(1);
    end
    rand_rdy[1] = 1'b0;
    set_out_rdy(1, 1'b1);
    drain(1);
  endtask

  task automatic checkOutput();
    @(negedge clk);
    cmp(0, "final_pending", exp_q[0].size(), 32'd0);
    cmp(1, "final_pending", exp_q[1].size(), 32'd0);
  endtask

  initial begin
    nrst0 = 1'b0;
    nrst1 = 1'b0;
    rand_rdy[0] = 1'b0;
    rand_rdy[1] = 1'b0;
    part_n[0] = 0; part_n[1] = 0;
    part_sum[0] = '0; part_sum[1] = '0;
    exp_gc[0] = '0; exp_gc[1] = '0;
    drive_in(0, 1'b0, 32'd0);
    drive_in(1, 1'b0, 32'd0);
    set_out_rdy(0, 1'b0);
    set_out_rdy(1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    nrst0 = 1'b1;
    nrst1 = 1'b1;
    @(negedge clk);
    cmp(0, "reset_group_count", {16'd0, if0.group_count}, 32'd0);
    cmp(0, "reset_busy", {31'd0, if0.busy}, 32'd0);
    cmp(1, "reset_group_count", {16'd0, if1.group_count}, 32'd0);
    tick(0);
    applyStimulus();
    checkOutput();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
